// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryptor. Runs one cipher round per clock and
// expands the key schedule on the fly. The key length is set by KEY_BITS.
// aes_sbox is the shared byte substitution used by both the datapath and the key path.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = p;
        for (int k = 0; k < 8; k++) begin
            if (q[k]) acc = acc ^ sh;
            sh = xt(sh);
        end
        return acc;
    endfunction

    logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;

    // GF(2^8) inverse computed as a^254 (which maps 0 to 0), followed by the affine transform
    always_comb begin
        p2   = gmul(a, a);
        p4   = gmul(p2, p2);
        p8   = gmul(p4, p4);
        p16  = gmul(p8, p8);
        p32  = gmul(p16, p16);
        p64  = gmul(p32, p32);
        p128 = gmul(p64, p64);
        inv  = gmul(gmul(gmul(p2, p4), gmul(p8, p16)), gmul(gmul(p32, p64), p128));
        y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam logic [3:0] NK4 = 4'(NK);
    localparam logic [3:0] NR4 = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
            $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] d);
        case (d)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    logic [7:0][31:0] k_q, k_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0]       imod_q, imod_d;   // (j+Nk) mod Nk for the words appended this cycle
    logic [3:0]       idiv_q, idiv_d;   // (j+Nk) div Nk, selects Rcon

    // Key window source: the raw key while idle, the running window otherwise
    logic [7:0][31:0] key_words, win, kn;
    logic [3:0][31:0] nw;
    logic [3:0]       base_mod, base_div, adv, imod_step, idiv_step, m, d, need;
    logic [31:0]      id_prev, chain_prev, sub_x, sub_in, sub_out, sub_f;
    logic             sub_rot, sub_found;
    logic [3:0]       sub_div;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key_words
            if (gi < NK) begin : g_used
                assign key_words[gi] = key_in[KEY_BITS-1-32*gi -: 32];
            end else begin : g_unused
                assign key_words[gi] = '0;
            end
        end
    endgenerate

    assign win = (fsm_q == S_IDLE) ? key_words : k_q;

    // Locate the (at most one) word of this group of four that needs SubWord, and its input
    always_comb begin
        base_mod  = (fsm_q == S_IDLE) ? 4'd0 : imod_q;
        base_div  = (fsm_q == S_IDLE) ? 4'd1 : idiv_q;
        adv       = base_mod + 4'd4;
        imod_step = (adv >= NK4) ? adv - NK4 : adv;
        idiv_step = (adv >= NK4) ? base_div + 4'd1 : base_div;
        need      = '0;
        m         = '0;
        d         = '0;
        sub_x     = win[NK-1];
        sub_rot   = 1'b0;
        sub_div   = '0;
        sub_found = 1'b0;
        id_prev   = win[NK-1];
        for (int t = 0; t < 4; t++) begin
            m = base_mod + 4'(t);
            d = base_div;
            if (m >= NK4) begin
                m = m - NK4;
                d = base_div + 4'd1;
            end
            need[t] = (m == 4'd0) || (NK == 8 && m == 4'd4);
            // Words ahead of the substituted one use the identity, so id_prev is exact here
            if (need[t] && !sub_found) begin
                sub_found = 1'b1;
                sub_x     = id_prev;
                sub_rot   = (m == 4'd0);
                sub_div   = d;
            end
            id_prev = win[t] ^ id_prev;
        end
    end

    assign sub_in = sub_rot ? {sub_x[23:0], sub_x[31:24]} : sub_x;
    assign sub_f  = sub_out ^ (sub_rot ? {rcon(sub_div), 24'h0} : 32'h0);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            aes_sbox u_key_sbox (.a(sub_in[31-8*gi -: 8]), .y(sub_out[31-8*gi -: 8]));
        end
    endgenerate

    // Compute the four new schedule words w[i] = w[i-Nk] ^ f(w[i-1])
    always_comb begin
        nw         = '0;
        chain_prev = win[NK-1];
        for (int t = 0; t < 4; t++) begin
            nw[t]      = win[t] ^ (need[t] ? sub_f : chain_prev);
            chain_prev = nw[t];
        end
    end

    generate
        for (gi = 0; gi < 8; gi++) begin : g_next_window
            if (gi < NK - 4) begin : g_shift
                assign kn[gi] = win[gi+4];
            end else if (gi < NK) begin : g_append
                assign kn[gi] = nw[gi-NK+4];
            end else begin : g_unused
                assign kn[gi] = '0;
            end
        end
    endgenerate

    // Round datapath: SubBytes, ShiftRows, MixColumns (skipped in the final round), AddRoundKey
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [127:0] shifted, mixed, round_key, round_out;

    assign round_key = {k_q[0], k_q[1], k_q[2], k_q[3]};

    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            aes_sbox u_sbox (.a(state_q[127-8*gi -: 8]), .y(sb[gi]));
            assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
            assign shifted[127-8*gi -: 8] = sr[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mixed[127-32*gi -: 8] = xt(sr[4*gi]) ^ xt(sr[4*gi+1]) ^ sr[4*gi+1]
                                         ^ sr[4*gi+2] ^ sr[4*gi+3];
            assign mixed[119-32*gi -: 8] = sr[4*gi] ^ xt(sr[4*gi+1]) ^ xt(sr[4*gi+2])
                                         ^ sr[4*gi+2] ^ sr[4*gi+3];
            assign mixed[111-32*gi -: 8] = sr[4*gi] ^ sr[4*gi+1] ^ xt(sr[4*gi+2])
                                         ^ xt(sr[4*gi+3]) ^ sr[4*gi+3];
            assign mixed[103-32*gi -: 8] = xt(sr[4*gi]) ^ sr[4*gi] ^ sr[4*gi+1]
                                         ^ sr[4*gi+2] ^ xt(sr[4*gi+3]);
        end
    endgenerate

    assign round_out = ((rnd_q == NR4) ? shifted : mixed) ^ round_key;

    // Next-state logic: accept in IDLE, one round per cycle in ROUND, hold in DONE
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        k_d     = k_q;
        rnd_d   = rnd_q;
        imod_d  = imod_q;
        idiv_d  = idiv_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = data_in ^ {key_words[0], key_words[1], key_words[2], key_words[3]};
                    k_d     = kn;
                    rnd_d   = 4'd1;
                    imod_d  = imod_step;
                    idiv_d  = idiv_step;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = round_out;
                k_d     = kn;
                rnd_d   = rnd_q + 4'd1;
                imod_d  = imod_step;
                idiv_d  = idiv_step;
                if (rnd_q == NR4) fsm_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            k_q     <= '0;
            rnd_q   <= '0;
            imod_q  <= '0;
            idiv_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            k_q     <= k_d;
            rnd_q   <= rnd_d;
            imod_q  <= imod_d;
            idiv_q  <= idiv_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE) && !rst;
    assign out_valid = (fsm_q == S_DONE);
    assign data_out  = state_q;
endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: one instance per key length, driven from known-answer vectors.
module tb_aes_iter_core;
    typedef struct {
        int           unit;
        logic [127:0] pt;
        logic [255:0] key;   // left-aligned, unused low bits zero
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    logic [127:0] data_in;
    logic [255:0] key_in [3];
    wire  [2:0]   in_ready;
    wire  [2:0]   out_valid;
    wire  [127:0] data_out [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    // Free-running cycle count, used to measure accept spacing
    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_core #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in), .key_in(key_in[0][255:128]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .data_out(data_out[0]));

    aes_iter_core #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in), .key_in(key_in[1][255:64]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .data_out(data_out[1]));

    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .data_in(data_in), .key_in(key_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .data_out(data_out[2]));

    function automatic int nr_of(input int u);
        return 10 + 2 * u;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        while (in_ready[u] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Accept one block, scramble the inputs while it runs, check latency and ciphertext
    task automatic run_block(input int u, input vec_t v, input string tag);
        int lat;
        wait_ready(u);
        chk({tag, " in_ready"}, 128'(in_ready[u]), 128'(1));
        data_in    = v.pt;
        key_in[u]  = v.key;
        in_valid[u] = 1'b1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 40) begin
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            key_in[u] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(nr_of(u)));
        chk({tag, " data_out"}, data_out[u], v.ct);
        $display("block %s unit %0d latency %0d ct %h", tag, u, lat, data_out[u]);
    endtask

    initial begin
        int   lat;
        int   acc [3];
        logic hold_ok;
        logic ov_seen;

        vecs[0] = '{0, 128'h00112233445566778899aabbccddeeff,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{1, 128'h00112233445566778899aabbccddeeff,
                    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[2] = '{2, 128'h00112233445566778899aabbccddeeff,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[3] = '{0, 128'h3243f6a8885a308d313198a2e0370734,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[4] = '{0, 128'h6bc1bee22e409f96e93d7e117393172a,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[5] = '{0, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'hf5d3d58503b9699de785895a96fdbaaf};
        vecs[6] = '{1, 128'h6bc1bee22e409f96e93d7e117393172a,
                    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                    128'hbd334f1d6e45f25ff712a214571fa5cc};
        vecs[7] = '{2, 128'h6bc1bee22e409f96e93d7e117393172a,
                    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'hf3eed1bdb5d2a03c064b5a7e3db181f8};

        rst       = 1'b1;
        in_valid  = 3'b000;
        out_ready = 3'b111;
        data_in   = '0;
        for (int i = 0; i < 3; i++) key_in[i] = '0;

        // Reset state
        #2;
        for (int u = 0; u < 3; u++) chk($sformatf("reset data_out%0d", u), data_out[u], 128'h0);
        chk("reset in_ready", 128'(in_ready), 128'(0));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after release", 128'(in_ready), 128'(3'b111));

        // Known-answer table across all three key lengths
        for (int i = 0; i < 8; i++) run_block(vecs[i].unit, vecs[i], $sformatf("vec%0d", i));

        // Backpressure: DONE holds with data_out stable and no accept
        out_ready[0] = 1'b0;
        run_block(0, vecs[3], "bp");
        hold_ok     = 1'b1;
        in_valid[0] = 1'b1;
        data_in     = vecs[4].pt;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || data_out[0] !== vecs[3].ct)
                hold_ok = 1'b0;
        end
        chk("bp hold stable", 128'(hold_ok), 128'(1));
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp release out_valid", 128'(out_valid[0]), 128'(0));
        chk("bp release in_ready", 128'(in_ready[0]), 128'(1));

        // Back-to-back with in_valid and out_ready held high
        in_valid[0] = 1'b1;
        key_in[0]   = vecs[3].key;
        for (int b = 0; b < 3; b++) begin
            wait_ready(0);
            chk($sformatf("b2b%0d in_ready", b), 128'(in_ready[0]), 128'(1));
            acc[b]  = cyc;
            data_in = vecs[3+b].pt;
            @(negedge clk);
            lat = 0;
            while (out_valid[0] !== 1'b1 && lat < 40) begin
                data_in = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                lat++;
            end
            chk($sformatf("b2b%0d data_out", b), data_out[0], vecs[3+b].ct);
            $display("block b2b%0d unit 0 latency %0d ct %h", b, lat, data_out[0]);
        end
        in_valid[0] = 1'b0;
        chk("b2b spacing 0-1", 128'(acc[1] - acc[0]), 128'(12));
        chk("b2b spacing 1-2", 128'(acc[2] - acc[1]), 128'(12));

        // Reset in the middle of a block
        wait_ready(0);
        data_in     = vecs[0].pt;
        key_in[0]   = vecs[0].key;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", 128'(out_valid[0]), 128'(0));
        chk("midrst data_out", data_out[0], 128'h0);
        chk("midrst in_ready", 128'(in_ready[0]), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst in_ready after release", 128'(in_ready[0]), 128'(1));
        ov_seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) ov_seen = 1'b1;
        end
        chk("midrst no out_valid pulse", 128'(ov_seen), 128'(0));
        run_block(0, vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait above never resolves
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
